// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit seven-segment driver with a per-slot blanking gap.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [15:0] Digits,
  input  logic [3:0]  DpMask,
  input  logic        Load,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic [3:0]  An,
  output logic        FrameTick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(SCAN_DIV - 1);

  typedef enum logic {BLANK, DRIVE} phase_t;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   dig_q;
  logic [3:0]    dp_q;
  logic          wrap;
  logic          frame_pend;
  logic          frame_tick;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;
  logic          slot_supp;
  phase_t        phase;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;

  assign wrap = (cnt == LAST_C);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      dig_q      <= '0;
      dp_q       <= '0;
      frame_pend <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      if (Load) begin
        dig_q <= Digits;
        dp_q  <= DpMask;
      end
      // Delayed one cycle so the pulse lines up with the first blank of digit0 on the pins
      frame_pend <= wrap && (idx == 2'd3);
      frame_tick <= frame_pend;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [3:0] supp;
  always_comb begin
    supp    = '0;
    supp[3] = (dig_q[15:12] == 4'd0) && !dp_q[3];
    supp[2] = supp[3] && (dig_q[11:8] == 4'd0) && !dp_q[2];
    supp[1] = supp[2] && (dig_q[7:4]  == 4'd0) && !dp_q[1];
  end
  assign slot_supp = supp[idx];
`else
  assign slot_supp = 1'b0;
`endif

  assign cur_digit = dig_q[{idx, 2'b00} +: 4];

  always_comb begin
    phase = DRIVE;
    if ((int'(cnt) < BLANK_CYCLES) || slot_supp) phase = BLANK;
  end

  always_comb begin
    cur_seg = 7'h40;
    case (cur_digit)
      4'd0: cur_seg = 7'h3F;
      4'd1: cur_seg = 7'h06;
      4'd2: cur_seg = 7'h5B;
      4'd3: cur_seg = 7'h4F;
      4'd4: cur_seg = 7'h66;
      4'd5: cur_seg = 7'h6D;
      4'd6: cur_seg = 7'h7D;
      4'd7: cur_seg = 7'h07;
      4'd8: cur_seg = 7'h7F;
      4'd9: cur_seg = 7'h6F;
      default: cur_seg = 7'h40;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      an_r  <= '0;
      seg_r <= '0;
      dp_r  <= 1'b0;
    end else if (phase == DRIVE) begin
      an_r  <= 4'b0001 << idx;
      seg_r <= cur_seg;
      dp_r  <= dp_q[idx];
    end else begin
      an_r  <= '0;
      seg_r <= '0;
      dp_r  <= 1'b0;
    end
  end

  assign An        = (ACTIVE_LOW != 0) ? ~an_r  : an_r;
  assign Seg       = (ACTIVE_LOW != 0) ? ~seg_r : seg_r;
  assign Dp        = (ACTIVE_LOW != 0) ? ~dp_r  : dp_r;
  assign FrameTick = frame_tick;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream stage of the decade counters in the synchronous display counter design.
- Takes four 4-bit BCD digits from the counter chain and captures them coherently on a load strobe.
- Time-multiplexes the digits onto a common-anode 4-digit seven-segment display, with a per-digit blanking gap to prevent ghosting.
- Produces a frame tick for downstream or debug use.

Parameters:
- SCAN_DIV, 50000, clocks per digit slot (1 kHz/digit at 50 MHz); must be >= 2.
- BLANK_CYCLES, 500, clocks at the start of each slot with all anodes off; must satisfy 0 <= BLANK_CYCLES < SCAN_DIV.
- ACTIVE_LOW, 1, 1: An/Seg/Dp pins are active-low; 0: active-high.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- Digits  in  16  BCD digits; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
- DpMask  in  4  decimal-point enables; bit i belongs to digit i.
- Load  in  1  when high at a posedge, Digits/DpMask are captured into the snapshot.
- Seg  out  7  segments; Seg[0]=a .. Seg[6]=g.
- Dp  out  1  decimal point.
- An  out  4  digit enables, one-hot or none; bit i drives digit i.
- FrameTick  out  1  one-cycle pulse per full 4-digit scan.

Behaviour:
- Snapshot: Dig_q[15:0] and Dp_q[3:0], reset 0; loaded when Load=1, otherwise held. Only the snapshot is displayed; Digits changes without Load have no effect.
- Prescaler: Cnt counts 0..SCAN_DIV-1, increments every clock and wraps to 0.
- Digit index: Idx[1:0], reset 0; increments on the Cnt wrap, sequence 0→1→2→3→0.
- Slot FSM, per slot:
  - BLANK while Cnt < BLANK_CYCLES: no anode active.
  - DRIVE while Cnt >= BLANK_CYCLES: An bit Idx active; Seg/Dp show snapshot digit Idx.
  - BLANK_CYCLES=0 means the slot is DRIVE-only.
- Decode (logical, 1=segment lit, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Codes 10–15 (invalid BCD) show '-' = 40.
- Dp logical = Dp_q[Idx] during DRIVE; 0 during BLANK.
- Polarity: when ACTIVE_LOW=1, An/Seg/Dp pins are the bitwise inverse of the logical values.
- Outputs are registered: pins at cycle n+1 reflect (Cnt, Idx, Dig_q, Dp_q) at cycle n. Latency from Load edge to visible pins is at most one frame plus 2 cycles.
- Load on the same edge as a slot wrap: the new slot uses the new snapshot; the register stage guarantees this.
- FrameTick: registered; high for exactly one cycle after the edge at which Idx wraps 3→0. One pulse per 4*SCAN_DIV cycles.
- Reset values (async, while Rst_n=0):
  - Cnt=0, Idx=0, state BLANK, FrameTick=0.
  - Logical An/Seg/Dp all 0, so pins are all 1 when ACTIVE_LOW=1.
- Reset release: first DRIVE on digit0 appears on the pins at cycle BLANK_CYCLES+1.
- Reset mid-scan: outputs blank immediately and the scan restarts from digit0; the snapshot is cleared to 0.

Optional Feature:
- SEG7_LZ_BLANK_EN defined: leading-zero suppression.
  - Digit i (i=3..1) is suppressed when it and every more-significant digit in the snapshot equal 0.
  - A suppressed digit's slot stays BLANK for the whole slot; timing and FrameTick are unchanged.
  - Digit0 is never suppressed.
  - A set DpMask bit on a digit un-suppresses that digit.
- SEG7_LZ_BLANK_EN undefined: all four digits are always driven; the suppression logic is absent.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1):
- Hold Rst_n=0, then release → An=1111, Seg=7F, Dp=1 during reset; at cycle 3 after release An=1110, Seg=40 (digit "0").
- Load=1 with Digits=16'h1234, DpMask=0 → over one frame the DRIVE phases show An=1110/Seg=19, 1101/30, 1011/24, 0111/79; every slot starts with 2 cycles of An=1111.
- Snapshot 16'h00A9; change Digits to 16'h5555 without Load → digit1 continues to show Seg=3F ('-'), digit0 Seg=10; the 5s never appear.
- Count FrameTick over 96 cycles → exactly 3 pulses, 32 cycles apart, each coincident with the first blank of digit0.
- Assert Rst_n=0 asynchronously mid-DRIVE of digit2 → An=1111 within the same cycle, with no clock edge needed; after release, scanning restarts at digit0 showing 0.
- With SEG7_LZ_BLANK_EN, Load 16'h0050 → An bits 3,2 never go low; digit1 shows Seg=12, digit0 shows Seg=40. Load 16'h0000 with DpMask=0100 → digit2 shows 0 with Dp=0, digit1 shows 0, digit3 stays blank.
